adam_mem_arbiter: RTL and testbench



---
 rtl/adam_mem_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_adam_mem_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adam_mem_arbiter.sv
// adam_mem_arbiter: shares one external memory port between the Z80 CPU
// and the ADAMnet DMA block-transfer engine, with fairness and a watchdog.
//
// Ports:
//   clk_i, reset_n_i        clock, synchronous active-low reset
//   cpu_*                   CPU request (level), WAIT, done pulse, read data
//   dma_*                   DMA request (level until ack), ack pulse, read data
//   mem_*                   memory port: req held until ack, addr/data/we
//   err_o                   sticky bus-timeout flag
module adam_mem_arbiter #(
  parameter int AW          = 18,
  parameter int MAX_CPU_RUN = 4,
  parameter int TIMEOUT     = 63
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [7:0]    cpu_wdata_i,
  output logic [7:0]    cpu_rdata_o,
  output logic          cpu_wait_n_o,
  output logic          cpu_done_o,
  input  logic          dma_req_i,
  input  logic          dma_we_i,
  input  logic [AW-1:0] dma_addr_i,
  input  logic [7:0]    dma_wdata_i,
  output logic [7:0]    dma_rdata_o,
  output logic          dma_ack_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [7:0]    mem_wdata_o,
  input  logic [7:0]    mem_rdata_i,
  input  logic          mem_ack_i,
  output logic          err_o
);

  typedef enum logic [1:0] {
    IDLE,
    CPU_ACC,
    DMA_ACC,
    DONE
  } state_t;

  localparam logic [3:0] RUN_MAX  = 4'(MAX_CPU_RUN);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [3:0]    run_q, run_d;
  logic [7:0]    tmo_q, tmo_d;
  logic          armed_q, armed_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic [7:0]    cpu_rdata_q, cpu_rdata_d;
  logic [7:0]    dma_rdata_q, dma_rdata_d;
  logic          cpu_done_q, cpu_done_d;
  logic          dma_ack_q, dma_ack_d;
  logic          err_q, err_d;

  logic cpu_pend;
  logic dma_pend;
  logic owner_cpu;
  logic fin;
  logic [7:0] fin_data;

  assign cpu_pend  = cpu_req_i & armed_q;
  assign dma_pend  = dma_req_i;
  assign owner_cpu = (state_q == CPU_ACC);

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    tmo_d       = tmo_q;
    armed_d     = armed_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_rdata_d = cpu_rdata_q;
    dma_rdata_d = dma_rdata_q;
    cpu_done_d  = 1'b0;
    dma_ack_d   = 1'b0;
    err_d       = err_q;
    fin         = 1'b0;
    fin_data    = 8'hFF;

    // Re-arm once the Z80 cycle ends so each cycle yields one access.
    if (!cpu_req_i) armed_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (cpu_pend && (!dma_pend || run_q != RUN_MAX)) begin
          state_d     = CPU_ACC;
          armed_d     = 1'b0;
          run_d       = dma_req_i ?
                        ((run_q < RUN_MAX) ? run_q + 4'd1 : run_q) :
                        4'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = cpu_we_i;
          mem_addr_d  = cpu_addr_i;
          mem_wdata_d = cpu_wdata_i;
          tmo_d       = 8'd0;
        end else if (dma_pend) begin
          state_d     = DMA_ACC;
          run_d       = 4'd0;
          mem_req_d   = 1'b1;
          mem_we_d    = dma_we_i;
          mem_addr_d  = dma_addr_i;
          mem_wdata_d = dma_wdata_i;
          tmo_d       = 8'd0;
        end
      end
      CPU_ACC, DMA_ACC: begin
        tmo_d = tmo_q + 8'd1;
        // An ack on the timeout cycle wins over the abort.
        if (mem_ack_i) begin
          fin      = 1'b1;
          fin_data = mem_rdata_i;
        end else if (tmo_q == TMO_LAST) begin
          fin      = 1'b1;
          fin_data = 8'hFF;
          err_d    = 1'b1;
        end
        if (fin) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          if (owner_cpu) begin
            cpu_done_d = 1'b1;
            if (!mem_we_q) cpu_rdata_d = fin_data;
          end else begin
            dma_ack_d = 1'b1;
            if (!mem_we_q) dma_rdata_d = fin_data;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q     <= IDLE;
      run_q       <= 4'd0;
      tmo_q       <= 8'd0;
      armed_q     <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      cpu_rdata_q <= 8'hFF;
      dma_rdata_q <= 8'hFF;
      cpu_done_q  <= 1'b0;
      dma_ack_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      tmo_q       <= tmo_d;
      armed_q     <= armed_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
      cpu_done_q  <= cpu_done_d;
      dma_ack_q   <= dma_ack_d;
      err_q       <= err_d;
    end
  end

  // WAIT: low while this Z80 cycle's access is pending or in flight.
  assign cpu_wait_n_o = ~(cpu_req_i & ~cpu_done_q &
                          (armed_q | owner_cpu));

  assign cpu_rdata_o = cpu_rdata_q;
  assign cpu_done_o  = cpu_done_q;
  assign dma_rdata_o = dma_rdata_q;
  assign dma_ack_o   = dma_ack_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_adam_mem_arbiter.sv
// tb_adam_mem_arbiter: directed stimulus with a queue-based scoreboard
// for the CPU/DMA memory arbiter.
module tb_adam_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [17:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_wait_n;
  logic        cpu_done;
  logic        dma_req = 1'b0;
  logic        dma_we = 1'b0;
  logic [17:0] dma_addr = '0;
  logic [7:0]  dma_wdata = '0;
  logic [7:0]  dma_rdata;
  logic        dma_ack;
  logic        mem_req;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        err;

  adam_mem_arbiter dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .cpu_req_i    (cpu_req),
    .cpu_we_i     (cpu_we),
    .cpu_addr_i   (cpu_addr),
    .cpu_wdata_i  (cpu_wdata),
    .cpu_rdata_o  (cpu_rdata),
    .cpu_wait_n_o (cpu_wait_n),
    .cpu_done_o   (cpu_done),
    .dma_req_i    (dma_req),
    .dma_we_i     (dma_we),
    .dma_addr_i   (dma_addr),
    .dma_wdata_i  (dma_wdata),
    .dma_rdata_o  (dma_rdata),
    .dma_ack_o    (dma_ack),
    .mem_req_o    (mem_req),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata),
    .mem_ack_i    (mem_ack),
    .err_o        (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 grant, 1 cpu done, 2 dma ack
    logic [17:0] addr;
    logic        we;
    logic [7:0]  data;
    logic        err;
  } ev_t;

  ev_t sb[$];
  int  total = 0;
  int  bad = 0;
  int  grants = 0;
  int  ack_dly = 0;
  int  mcnt = 0;
  logic [7:0] rd_val = 8'h00;
  logic req_prev = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [17:0] a, input logic w,
                      input logic [7:0] d, input logic e);
    ev_t ev;
    ev.kind = k;
    ev.addr = a;
    ev.we   = w;
    ev.data = d;
    ev.err  = e;
    sb.push_back(ev);
  endtask

  task automatic take(input int k);
    ev_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_event: got kind %0d expected none", k);
    end else begin
      e = sb.pop_front();
      chk("event_kind", k, e.kind);
      if (k == 0 && e.kind == 0) begin
        chk("grant_addr", 32'(mem_addr), 32'(e.addr));
        chk("grant_we", 32'(mem_we), 32'(e.we));
        if (e.we) chk("grant_wdata", 32'(mem_wdata), 32'(e.data));
      end else if (k == 1 && e.kind == 1) begin
        chk("cpu_rdata", 32'(cpu_rdata), 32'(e.data));
        chk("cpu_err", 32'(err), 32'(e.err));
      end else if (k == 2 && e.kind == 2) begin
        chk("dma_rdata", 32'(dma_rdata), 32'(e.data));
      end
    end
  endtask

  // Memory model: ack ack_dly cycles after mem_req rises.
  always @(negedge clk) begin
    if (mem_req) begin
      if (mcnt == ack_dly) begin
        mem_ack   = 1'b1;
        mem_rdata = rd_val;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
      end
      mcnt++;
    end else begin
      mcnt      = 0;
      mem_ack   = 1'b0;
      mem_rdata = 8'h00;
    end
  end

  // Monitor: pops and compares whenever the DUT presents an event.
  always @(negedge clk) begin
    if (reset_n) begin
      if (mem_req && !req_prev) begin
        grants++;
        take(0);
      end
      if (cpu_done) take(1);
      if (dma_ack) take(2);
    end
    req_prev = mem_req;
  end

  task automatic do_reset();
    reset_n = 1'b0;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_cpu(input logic [17:0] a, input logic w,
                         input logic [7:0] wd, input logic [7:0] exp_rd,
                         input logic exp_err, input int exp_hi);
    int hi = 0;
    logic wait_ok = 1'b1;
    logic we_ok = 1'b1;
    logic seen = 1'b0;
    push(0, a, w, wd, 1'b0);
    push(1, 18'h0, 1'b0, exp_rd, exp_err);
    cpu_addr  = a;
    cpu_we    = w;
    cpu_wdata = wd;
    cpu_req   = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (cpu_done) begin
        seen = 1'b1;
        break;
      end
      if (mem_req) hi++;
      if (cpu_wait_n !== 1'b0) wait_ok = 1'b0;
      if (mem_we !== w) we_ok = 1'b0;
    end
    chk("cpu_done_seen", 32'(seen), 32'd1);
    chk("wait_low_during", 32'(wait_ok), 32'd1);
    chk("mem_we_steady", 32'(we_ok), 32'd1);
    chk("wait_high_at_done", 32'(cpu_wait_n), 32'd1);
    chk("mem_req_cycles", hi, exp_hi);
    cpu_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int g0;
    int cpu_left;
    int dma_left;
    logic no_ack;

    // Reset values
    do_reset();
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_cpu_rdata", 32'(cpu_rdata), 32'hFF);
    chk("rst_dma_rdata", 32'(dma_rdata), 32'hFF);
    chk("rst_wait_n", 32'(cpu_wait_n), 32'd1);
    chk("rst_err", 32'(err), 32'd0);

    // CPU read, ack 3 cycles after request
    ack_dly = 3;
    rd_val  = 8'h5A;
    run_cpu(18'h02000, 1'b0, 8'h00, 8'h5A, 1'b0, 4);

    // Fairness: 8 CPU reads vs continuous DMA write
    ack_dly   = 0;
    rd_val    = 8'h77;
    cpu_addr  = 18'h00100;
    cpu_we    = 1'b0;
    dma_addr  = 18'h10000;
    dma_we    = 1'b1;
    dma_wdata = 8'h11;
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < 4; c++) begin
        push(0, 18'h00100, 1'b0, 8'h00, 1'b0);
        push(1, 18'h0, 1'b0, 8'h77, 1'b0);
      end
      push(0, 18'h10000, 1'b1, 8'h11, 1'b0);
      push(2, 18'h0, 1'b0, 8'hFF, 1'b0);
    end
    cpu_left = 8;
    dma_left = 2;
    cpu_req  = 1'b1;
    dma_req  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (mem_req && mem_addr == 18'h00100 && cpu_req) begin
        cpu_req = 1'b0;
        cpu_left--;
      end
      if (cpu_done && cpu_left > 0) cpu_req = 1'b1;
      if (dma_ack) begin
        dma_left--;
        if (dma_left == 0) dma_req = 1'b0;
      end
      if (cpu_left == 0 && dma_left == 0) break;
    end
    chk("fair_cpu_left", cpu_left, 0);
    chk("fair_dma_left", dma_left, 0);
    repeat (4) @(negedge clk);
    chk("fair_sb_empty", sb.size(), 0);

    // CPU request held high: one access only
    rd_val   = 8'h42;
    cpu_addr = 18'h00200;
    cpu_we   = 1'b0;
    push(0, 18'h00200, 1'b0, 8'h00, 1'b0);
    push(1, 18'h0, 1'b0, 8'h42, 1'b0);
    g0 = grants;
    cpu_req = 1'b1;
    repeat (20) @(negedge clk);
    chk("held_one_grant", grants - g0, 1);
    chk("held_wait_n", 32'(cpu_wait_n), 32'd1);
    cpu_req = 1'b0;
    @(negedge clk);
    rd_val = 8'h43;
    run_cpu(18'h00201, 1'b0, 8'h00, 8'h43, 1'b0, 1);
    // Write must not disturb cpu_rdata
    rd_val = 8'hEE;
    run_cpu(18'h00300, 1'b1, 8'hA5, 8'h43, 1'b0, 1);

    // Timeout without ack
    ack_dly = 1000;
    rd_val  = 8'h99;
    run_cpu(18'h03000, 1'b0, 8'h00, 8'hFF, 1'b1, 63);
    repeat (10) @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    do_reset();
    chk("err_cleared", 32'(err), 32'd0);

    // Ack on the timeout cycle
    ack_dly = 62;
    rd_val  = 8'h33;
    run_cpu(18'h03001, 1'b0, 8'h00, 8'h33, 1'b0, 63);

    // Reset in the middle of a DMA access
    ack_dly  = 1000;
    dma_addr = 18'h10005;
    dma_we   = 1'b0;
    push(0, 18'h10005, 1'b0, 8'h00, 1'b0);
    dma_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) break;
    end
    chk("dma_granted", 32'(mem_req), 32'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    dma_req = 1'b0;
    @(negedge clk);
    chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
    chk("mid_rst_dma_ack", 32'(dma_ack), 32'd0);
    chk("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_rst_dma_rdata", 32'(dma_rdata), 32'hFF);
    chk("mid_rst_cpu_rdata", 32'(cpu_rdata), 32'hFF);
    reset_n = 1'b1;
    no_ack = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (dma_ack) no_ack = 1'b0;
    end
    chk("mid_rst_no_ack", 32'(no_ack), 32'd1);
    // Idle after reset: next access grants immediately
    ack_dly = 0;
    rd_val  = 8'hC3;
    run_cpu(18'h00010, 1'b0, 8'h00, 8'hC3, 1'b0, 1);

    repeat (4) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
